// File: rtl/elevator_motion_controller.sv
// elevator_motion_controller: SCAN elevator FSM; in upcall/downcall/floor_btn/open_btn, out floor/status/dir_up/door_open
module elevator_motion_controller #(
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] upcall,
  input  logic [7:0] downcall,
  input  logic [7:0] floor_btn,
  input  logic       open_btn,
  output logic [2:0] floor,
  output logic [3:0] status,
  output logic       dir_up,
  output logic       door_open
);
  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    MOVE_UP    = 4'd1,
    MOVE_DOWN  = 4'd2,
    ARRIVE     = 4'd3,
    DOOR_OPEN  = 4'd7,
    DOOR_CLOSE = 4'd8
  } state_t;
  state_t state_q, state_d;
  logic [2:0] floor_q, floor_d;
  logic dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] req;
  logic above, below, here, ahead, stop;
  always_comb begin
    req = upcall | downcall | floor_btn;
    above = |(req & (8'hFE << floor_q));
    below = |(req & ~(8'hFF << floor_q));
    here = req[floor_q];
    ahead = dir_q ? above : below;
    stop = floor_btn[floor_q] | (dir_q & upcall[floor_q]) | (!dir_q & downcall[floor_q]) | (here & !ahead);
    state_d = state_q;
    floor_d = floor_q;
    dir_d = dir_q;
    cnt_d = '0;
    case (state_q)
      IDLE, DOOR_CLOSE: begin
        if (here) state_d = DOOR_OPEN;
        else if (above || below) begin
          dir_d = (above && below) ? dir_q : above;
          state_d = dir_d ? MOVE_UP : MOVE_DOWN;
        end else state_d = IDLE;
      end
      MOVE_UP, MOVE_DOWN: begin
        if (cnt_q == CNT_W'(MOVE_CYCLES - 1)) begin
          floor_d = (state_q == MOVE_UP) ? floor_q + 3'd1 : floor_q - 3'd1;
          state_d = ARRIVE;
        end else cnt_d = cnt_q + 1'b1;
      end
      ARRIVE: state_d = stop ? DOOR_OPEN : ahead ? (dir_q ? MOVE_UP : MOVE_DOWN) : IDLE;
      DOOR_OPEN: begin
        if (!open_btn) begin
          if (cnt_q == CNT_W'(DOOR_CYCLES - 1)) state_d = DOOR_CLOSE;
          else cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      floor_q <= '0;
      dir_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q <= dir_d;
      cnt_q <= cnt_d;
    end
  end
  assign floor = floor_q;
  assign status = state_q;
  assign dir_up = dir_q;
  assign door_open = state_q == DOOR_OPEN;
endmodule

// File: tb/tb_elevator_motion_controller.sv
// tb_elevator_motion_controller: directed SCAN scenarios with a request-buffer emulation
module tb_elevator_motion_controller;
  logic clk, rst, open_btn;
  logic [7:0] up_q, dn_q, fb_q, add_up, add_dn, add_fb, clr;
  logic [2:0] floor;
  logic [3:0] status;
  logic dir_up, door_open;
  int checks, errs;
  elevator_motion_controller dut (
    .clk(clk), .rst(rst), .upcall(up_q), .downcall(dn_q), .floor_btn(fb_q),
    .open_btn(open_btn), .floor(floor), .status(status), .dir_up(dir_up), .door_open(door_open)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  assign clr = (status == 4'd7) ? (8'd1 << floor) : 8'd0;
  always @(posedge clk) begin
    if (!rst) begin
      up_q <= '0;
      dn_q <= '0;
      fb_q <= '0;
    end else begin
      up_q <= (up_q | add_up) & ~clr;
      dn_q <= (dn_q | add_dn) & ~clr;
      fb_q <= (fb_q | add_fb) & ~clr;
    end
  end
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic run(input string tag, input int st, input int fl, input bit d, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, {7'd0, door_open, dir_up, status, floor}, {7'd0, st == 7, d, 4'(st), 3'(fl)});
      @(negedge clk);
    end
  endtask
  task automatic travel(input string tag, input int from, input int to, input bit d);
    int f, s;
    f = from;
    s = (to > from) ? 1 : -1;
    while (f != to) begin
      run(tag, (s > 0) ? 1 : 2, f, d, 4);
      f += s;
      run(tag, 3, f, d, 1);
    end
  endtask
  task automatic door(input string tag, input int fl, input bit d);
    run(tag, 7, fl, d, 3);
    run(tag, 8, fl, d, 1);
  endtask
  task automatic press(input logic [7:0] u, input logic [7:0] dn, input logic [7:0] f);
    add_up = u;
    add_dn = dn;
    add_fb = f;
    @(negedge clk);
    add_up = '0;
    add_dn = '0;
    add_fb = '0;
  endtask
  initial begin
    checks = 0;
    errs = 0;
    rst = 1'b0;
    open_btn = 1'b0;
    add_up = '0;
    add_dn = '0;
    add_fb = '0;
    repeat (3) @(negedge clk);
    run("reset", 0, 0, 1, 1);
    rst = 1'b1;
    run("idle_hold", 0, 0, 1, 20);
    press(8'h00, 8'h00, 8'h08);
    run("t2_idle", 0, 0, 1, 1);
    travel("t2_up", 0, 3, 1);
    door("t2_door", 3, 1);
    run("t2_end", 0, 3, 1, 2);
    press(8'h00, 8'h00, 8'h04);
    run("t3a_idle", 0, 3, 1, 1);
    travel("t3a_dn", 3, 2, 0);
    door("t3a_door", 2, 0);
    run("t3a_end", 0, 2, 0, 2);
    press(8'h20, 8'h10, 8'h40);
    run("t3_idle", 0, 2, 0, 1);
    travel("t3_up5", 2, 5, 1);
    door("t3_door5", 5, 1);
    travel("t3_up6", 5, 6, 1);
    door("t3_door6", 6, 1);
    travel("t3_dn4", 6, 4, 0);
    door("t3_door4", 4, 0);
    run("t3_end", 0, 4, 0, 2);
    press(8'h00, 8'h00, 8'h08);
    run("t4_idle", 0, 4, 0, 1);
    travel("t4_dn", 4, 3, 0);
    run("t4_dwell1", 7, 3, 0, 1);
    open_btn = 1'b1;
    run("t4_dwell2", 7, 3, 0, 1);
    open_btn = 1'b0;
    run("t4_ext", 7, 3, 0, 3);
    run("t4_close", 8, 3, 0, 1);
    run("t4_end", 0, 3, 0, 2);
    press(8'h00, 8'h00, 8'h10);
    run("t5a_idle", 0, 3, 0, 1);
    travel("t5a_up", 3, 4, 1);
    door("t5a_door", 4, 1);
    run("t5a_end", 0, 4, 1, 2);
    press(8'h80, 8'h01, 8'h00);
    run("t5_idle", 0, 4, 1, 1);
    travel("t5_up7", 4, 7, 1);
    door("t5_door7", 7, 1);
    travel("t5_dn0", 7, 0, 0);
    door("t5_door0", 0, 0);
    run("t5_end", 0, 0, 0, 2);
    press(8'h00, 8'h00, 8'h20);
    run("t6a_idle", 0, 0, 0, 1);
    travel("t6a_up", 0, 5, 1);
    door("t6a_door", 5, 1);
    run("t6a_end", 0, 5, 1, 2);
    press(8'h00, 8'h00, 8'h02);
    run("t6_idle", 0, 5, 1, 1);
    run("t6_move", 2, 5, 0, 2);
    rst = 1'b0;
    #1;
    chk("t6_rst_offedge", {7'd0, door_open, dir_up, status, floor}, {7'd0, 1'b0, 1'b0, 4'd2, 3'd5});
    @(negedge clk);
    chk("t6_rst_snap", {7'd0, door_open, dir_up, status, floor}, {7'd0, 1'b0, 1'b1, 4'd0, 3'd0});
    rst = 1'b1;
    @(negedge clk);
    run("t6_after", 0, 0, 1, 5);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/elevator_motion_controller.md
Name: elevator_motion_controller

Overview:
Central elevator state machine that consumes the latched request vectors (upcall, downcall, floor_btn) from the request-buffer stage and produces the current floor and status code. The buffer uses those outputs to clear serviced requests. Scheduling is SCAN: keep the current direction while requests lie ahead, reverse when none do, idle when no requests remain. Floor travel time and door dwell are modelled with cycle counters.

Parameters:
MOVE_CYCLES, 4, clock cycles to travel one floor (≥2)
DOOR_CYCLES, 3, clock cycles door stays open (≥1)
CNT_W, 4, width of the shared move/door counter (must hold max(MOVE_CYCLES, DOOR_CYCLES))

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  synchronous, active-low reset
upcall  input  8  latched up-call requests, bit i = floor i
downcall  input  8  latched down-call requests
floor_btn  input  8  latched in-car floor requests
open_btn  input  1  door-hold request; restarts door dwell while door is open
floor  output  3  current floor, 0..7
status  output  4  state code: 0 IDLE, 1 MOVE_UP, 2 MOVE_DOWN, 3 ARRIVE, 7 DOOR_OPEN, 8 DOOR_CLOSE
dir_up  output  1  current scan direction, 1 = up
door_open  output  1  high exactly when status==7

Behaviour:
- Reset (rst==0 at posedge): floor=0, status=IDLE, dir_up=1, counter=0, door_open=0. Reset overrides everything, including mid-move and mid-door; the floor snaps to 0.
- Derived, combinational from the inputs:
  - req = upcall|downcall|floor_btn
  - above = |(req bits with index > floor)
  - below = |(req bits with index < floor)
  - here = req[floor]
- Outputs are registered state; status/floor change only on clock edges.
- IDLE:
  - here → DOOR_OPEN.
  - Else above&&below → move in the dir_up direction.
  - Else above → MOVE_UP, dir_up=1.
  - Else below → MOVE_DOWN, dir_up=0.
  - Else stay in IDLE.
  - Counter cleared on every exit.
- MOVE_UP / MOVE_DOWN:
  - Counter increments each cycle.
  - When counter==MOVE_CYCLES-1: floor ±1, counter=0, → ARRIVE.
  - Floor never wraps. MOVE_UP is entered only when above=1, so floor<7; MOVE_DOWN only when below=1, so floor>0.
  - Requests arriving mid-move do not abort the move.
- ARRIVE (one cycle, decision at the new floor). Stop (→ DOOR_OPEN) when any of:
  - floor_btn[floor]
  - dir_up && upcall[floor]
  - !dir_up && downcall[floor]
  - here && no request ahead in the current direction
  
  Otherwise, request ahead → continue in the same direction. Otherwise → IDLE.
- DOOR_OPEN (status 7):
  - Counter counts 0..DOOR_CYCLES-1, then → DOOR_CLOSE.
  - open_btn==1 in any DOOR_OPEN cycle resets the counter to 0, so the dwell is extended.
  - The buffer clears req[floor] on each edge where status==7. Because of that one-cycle pipeline, req[floor] may still read 1 in the first DOOR_OPEN cycle; the controller ignores `here` while in DOOR_OPEN.
- DOOR_CLOSE (status 8, one cycle):
  - here → DOOR_OPEN. This covers a floor button pressed at the current floor during dwell, which the buffer keeps set.
  - Else dir_up&&above → MOVE_UP.
  - Else !dir_up&&below → MOVE_DOWN.
  - Else above → MOVE_UP, dir_up=1.
  - Else below → MOVE_DOWN, dir_up=0.
  - Else → IDLE.
- dir_up changes only on the transitions listed above.
- Simultaneous requests at the current floor plus ahead: stop first, then continue.
- Illegal status values recover to IDLE on the next edge.

Test Plan:
- Reset then no requests: status 0, floor 0, dir_up 1, held for 20 cycles.
- From floor 0, floor_btn=8'b0000_1000 held until status==7 → status 1 for 3×4 cycles with floor 1,2,3, each passing ARRIVE; then status 7 at floor 3 for 3 cycles, then 8, then 0.
- Car moving up from floor 2 toward floor_btn[6]; downcall[4] and upcall[5] set → passes floor 4 without stopping, stops at 5 then 6, reverses, stops at 4 with dir_up=0.
- At floor 3 in DOOR_OPEN, open_btn pulsed on dwell cycle 2 → status 7 persists 3 more cycles after the pulse, total 5.
- Upcall[7] and downcall[0] both set in IDLE at floor 4 with dir_up=1 → goes up first to 7, then down to 0; floor never exceeds 7 or drops below 0.
- rst driven low during MOVE_DOWN at floor 5 → next edge floor 0, status 0, dir_up 1; asserting rst off-edge has no effect until the clock edge.
